tetris_gd_sync: RTL and testbench
=================================

# tetris_gd_sync

Frame-synchronous game-data buffer between the tetris game logic and `draw_tetris`. Game logic hands over a complete game-data snapshot with a valid/ready handshake. The block holds it in a shadow register and copies it to the output register only at the start of vertical sync. The draw pipeline therefore never renders a frame built from a mix of old and new data.

## Interface

Parameters:

- `OVERWRITE`, 1: 1 = latest snapshot wins while pending; 0 = back-pressure the writer until the swap.
- `VS_POLARITY`, 0: active level of `vga_vs_i`; 0 = active-low, matching the 1280x1024 timing.
- `FRAME_CNT_WIDTH`, 16: width of the frame counter.

Ports:

- `clk_i`  in  1  pixel clock (`clk_vga` domain). Single clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `gd_i`  in  `$bits(game_data_t)`  snapshot from game logic.
- `gd_valid_i`  in  1  snapshot on `gd_i` is valid.
- `gd_ready_o`  out  1  block accepts a snapshot. Transfer happens on a cycle with `gd_valid_i & gd_ready_o`.
- `vga_vs_i`  in  1  vertical sync from the timing generator, undelayed `pix_vs`.
- `gd_o`  out  `$bits(game_data_t)`  stable snapshot feeding `draw_tetris` game-data inputs.
- `swap_o`  out  1  one-cycle pulse in the cycle after `gd_o` was updated.
- `frame_cnt_o`  out  `FRAME_CNT_WIDTH`  count of vsync starts.
- `drop_cnt_o`  out  8  overwritten-before-display count. Present only with the configuration macro.

## Operation

- vsync start (`vs_start`):
  - `vs_d` registers `vga_vs_i`.
  - `vs_start` = (`vga_vs_i` == `VS_POLARITY`) & (`vs_d` != `VS_POLARITY`).
  - A held active level does not retrigger.
- States:
  - IDLE: `gd_o` equals the last accepted snapshot.
  - PENDING: the shadow holds a snapshot not yet shown.
- `gd_ready_o` = `!rst_i` & (state == IDLE | `OVERWRITE`).
- Transitions, evaluated per clock edge, where `acc` = `gd_valid_i & gd_ready_o`:
  - IDLE, `acc`: shadow <= `gd_i`, go to PENDING. A coincident `vs_start` does not swap.
  - PENDING, `vs_start`, no `acc`: `gd_o` <= shadow, `swap_o` <= 1, go to IDLE.
  - PENDING, `vs_start` and `acc` (OVERWRITE=1 only):
    - `gd_o` <= old shadow and `swap_o` <= 1.
    - shadow <= `gd_i`, stay in PENDING.
  - PENDING, `acc`, no `vs_start`: shadow <= `gd_i`. Drop counter increments.
  - Otherwise: hold.
- `frame_cnt_o` increments on every `vs_start`, regardless of state. Wraps modulo 2^`FRAME_CNT_WIDTH`.
- `drop_cnt_o` saturates at 255. It never increments when `OVERWRITE`=0.

## Timing

- Reset values, applied at the first clock edge with `rst_i`=1:
  - state IDLE.
  - shadow and `gd_o` all-zero: empty field, score/lines/level 0, `game_over_state`=0, `draw_en`=0.
  - `swap_o`=0, `frame_cnt_o`=0, `drop_cnt_o`=0, `vs_d`=!`VS_POLARITY`.
- Reset mid-PENDING discards the shadow; no swap is issued.
- `vs_start` is valid in the same cycle the sync level first appears on `vga_vs_i`.
- `gd_o` changes at the clock edge ending that cycle. `swap_o` is high for exactly the following cycle.
- Input-to-display latency: from acceptance to the next `vs_start` edge. Minimum 1 cycle; at most one frame plus 1 cycle.
- `gd_o` is constant between swaps. The vsync period gives `draw_tetris` (2-cycle latency) ample margin before active video.
- With `OVERWRITE`=0, `gd_ready_o` is low from the edge after acceptance until the edge after the swap.

## Configuration

- `TETRIS_GD_SYNC_DROP_CNT_EN`
  - Defined: the `drop_cnt_o` port and its 8-bit saturating counter exist.
  - Undefined: the port is absent and no counter logic is generated.
  - All other behaviour is identical in both builds.

## Structure

- `tetris_pkg` (shared package) holds:
  - `game_data_t`: packed struct of field, score[6][4], lines[6][4], level[6][4], next_block_data[64], next_block_color, next_block_rotation[2], next_block_draw_en, game_over_state. Widths come from `FIELD_ROW_CNT`, `FIELD_COL_CNT`, `TETRIS_COLORS_WIDTH`.
  - `gd_sync_state_t` enum {IDLE, PENDING}.
- Sub-module `vga_vs_edge`: registers vsync and outputs `vs_start`. Parameter `VS_POLARITY`. Reused by other frame-timed blocks.
- `draw_tetris` consumes `gd_o` fields unchanged.

## Test plan

- Reset and hold check:
  - Stimulus: assert `rst_i` 3 cycles with `gd_valid_i`=1, then release.
  - Required: `gd_o`=0, `gd_ready_o`=0 during reset, `frame_cnt_o`=0, `swap_o` never pulses.
- Single update:
  - Stimulus: accept snapshot with score=0x000123. Vsync falls 100 cycles later.
  - Required: `gd_o`.score stays 0 until that edge, then becomes 0x000123. `swap_o` is high exactly 1 cycle. `frame_cnt_o`=1.
- Latest-wins, `OVERWRITE`=1:
  - Stimulus: accept lines=1, 2, 3 within one frame, then vsync.
  - Required: `gd_o`.lines=3. `drop_cnt_o`=2 with the macro defined.
- Back-pressure, `OVERWRITE`=0:
  - Stimulus: accept level=5, then hold `gd_valid_i` high with level=6.
  - Required: `gd_ready_o` is low until the cycle after the first swap. Level 6 is accepted then and displayed at the second vsync.
- Simultaneous events:
  - Stimulus (`OVERWRITE`=1): while PENDING(A), present B on the `vs_start` cycle.
  - Required: `gd_o`=A and state PENDING(B). The next vsync gives `gd_o`=B.
  - Stimulus (separate case): in IDLE, accept C on the `vs_start` cycle.
  - Required: no swap that frame.
- Vsync level and wrap:
  - Stimulus: hold vsync active for 3 lines, over 2^16 frames.
  - Required: one `vs_start` per frame; `frame_cnt_o` wraps 0xFFFF -> 0. Reset asserted while PENDING leaves `gd_o`=0 after the next vsync.

Source files
------------

// File: rtl/tetris_pkg.sv
// tetris_pkg
//   Shared types for the tetris display path.
//   - game_data_t     : one complete game-data snapshot as consumed by draw_tetris
//   - gd_sync_state_t : state of the frame-synchronous game-data buffer
//   - GD_RESET        : all-zero snapshot (empty field, zero score/lines/level,
//                       game_over_state and next_block_draw_en low)
package tetris_pkg;

  localparam int FIELD_ROW_CNT       = 20;
  localparam int FIELD_COL_CNT       = 10;
  localparam int TETRIS_COLORS_WIDTH = 3;

  typedef logic [TETRIS_COLORS_WIDTH-1:0] tetris_color_t;

  // score/lines/level are six BCD digits each, most significant digit first.
  typedef struct packed {
    tetris_color_t [FIELD_ROW_CNT-1:0][FIELD_COL_CNT-1:0] field;
    logic [5:0][3:0]                                      score;
    logic [5:0][3:0]                                      lines;
    logic [5:0][3:0]                                      level;
    logic [63:0]                                          next_block_data;
    tetris_color_t                                        next_block_color;
    logic [1:0]                                           next_block_rotation;
    logic                                                 next_block_draw_en;
    logic                                                 game_over_state;
  } game_data_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } gd_sync_state_t;

  localparam game_data_t GD_RESET = '0;

endpackage

// File: rtl/tetris_gd_sync_vga_vs_edge.sv
// vga_vs_edge
//   Detects the start of vertical sync. vs_start_o is combinational and is
//   high in the same cycle the active sync level first appears on vs_i; a
//   held active level does not retrigger.
// Parameters:
//   VS_POLARITY : active level of vs_i (0 = active-low)
// Ports:
//   clk_i      in  pixel clock
//   rst_i      in  synchronous active-high reset
//   vs_i       in  raw vertical sync
//   vs_start_o out first cycle of the active sync level
module vga_vs_edge #(
  parameter bit VS_POLARITY = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vs_i,
  output logic vs_start_o
);

  logic vs_d_q;
  logic vs_d_d;

  always_comb begin
    vs_d_d = vs_i;
  end

  // Resetting to the inactive level lets a sync that is already active when
  // reset releases still count as a start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vs_d_q <= ~VS_POLARITY;
    end else begin
      vs_d_q <= vs_d_d;
    end
  end

  assign vs_start_o = (vs_i == VS_POLARITY) && (vs_d_q != VS_POLARITY);

endmodule

// File: rtl/tetris_gd_sync.sv
// tetris_gd_sync
//   Frame-synchronous game-data buffer. A snapshot accepted over the
//   valid/ready handshake is parked in a shadow register and copied to gd_o
//   only at the start of vertical sync, so draw_tetris never renders a frame
//   mixing old and new game data.
// Parameters:
//   OVERWRITE       : 1 = newest snapshot replaces a pending one,
//                     0 = writer is stalled until the pending one is shown
//   VS_POLARITY     : active level of vga_vs_i (0 = active-low)
//   FRAME_CNT_WIDTH : width of frame_cnt_o
// Configuration macro:
//   TETRIS_GD_SYNC_DROP_CNT_EN : adds drop_cnt_o, an 8-bit saturating count
//                                of pending snapshots replaced before display
// Ports:
//   clk_i       in  pixel clock
//   rst_i       in  synchronous active-high reset
//   gd_i        in  snapshot from game logic
//   gd_valid_i  in  gd_i is valid
//   gd_ready_o  out snapshot can be accepted this cycle
//   vga_vs_i    in  undelayed vertical sync
//   gd_o        out stable snapshot for draw_tetris
//   swap_o      out one-cycle pulse in the cycle after gd_o was updated
//   frame_cnt_o out number of vsync starts (wraps)
//   drop_cnt_o  out overwritten-before-display count (macro only)
module tetris_gd_sync
  import tetris_pkg::*;
#(
  parameter bit OVERWRITE       = 1'b1,
  parameter bit VS_POLARITY     = 1'b0,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  game_data_t                 gd_i,
  input  logic                       gd_valid_i,
  output logic                       gd_ready_o,
  input  logic                       vga_vs_i,
  output game_data_t                 gd_o,
  output logic                       swap_o,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o
`ifdef TETRIS_GD_SYNC_DROP_CNT_EN
  ,
  output logic [7:0]                 drop_cnt_o
`endif
);

  gd_sync_state_t             state_q, state_d;
  game_data_t                 shadow_q, shadow_d;
  game_data_t                 gd_q, gd_d;
  logic                       swap_q, swap_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                       vs_start;
  logic                       acc;

  vga_vs_edge #(
    .VS_POLARITY(VS_POLARITY)
  ) u_vs_edge (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .vs_i      (vga_vs_i),
    .vs_start_o(vs_start)
  );

  assign gd_ready_o = !rst_i && ((state_q == IDLE) || OVERWRITE);
  assign acc        = gd_valid_i && gd_ready_o;

  // A snapshot accepted in IDLE is never shown in the same vsync cycle; it
  // waits for the next frame. In PENDING a coincident accept refills the
  // shadow while the old shadow contents go out, so the state stays PENDING.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    gd_d        = gd_q;
    swap_d      = 1'b0;
    frame_cnt_d = frame_cnt_q + {{(FRAME_CNT_WIDTH-1){1'b0}}, vs_start};
    case (state_q)
      IDLE: begin
        if (acc) begin
          shadow_d = gd_i;
          state_d  = PENDING;
        end
      end
      PENDING: begin
        if (vs_start) begin
          gd_d   = shadow_q;
          swap_d = 1'b1;
          if (acc) begin
            shadow_d = gd_i;
          end else begin
            state_d = IDLE;
          end
        end else if (acc) begin
          shadow_d = gd_i;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      shadow_q    <= GD_RESET;
      gd_q        <= GD_RESET;
      swap_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      gd_q        <= gd_d;
      swap_q      <= swap_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign gd_o        = gd_q;
  assign swap_o      = swap_q;
  assign frame_cnt_o = frame_cnt_q;

`ifdef TETRIS_GD_SYNC_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       drop_inc;

  // Only a replacement that is not simultaneously displayed loses data.
  always_comb begin
    drop_inc   = (state_q == PENDING) && acc && !vs_start;
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_tetris_gd_sync.sv
// tb_tetris_gd_sync
//   Two instances share clock, reset and vsync: dut1 with OVERWRITE=1 and
//   dut0 with OVERWRITE=0. Both use an 8-bit frame counter so the wrap is
//   reachable in a short run. Expected displayed snapshots are queued by the
//   stimulus and popped by a monitor whenever a swap pulse appears.
module tb_tetris_gd_sync;
  import tetris_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       vsync;
  game_data_t gdIn1, gdIn0, gdOut1, gdOut0;
  logic       valid1, valid0, ready1, ready0, swap1, swap0;
  logic [7:0] frame1, frame0;
`ifdef TETRIS_GD_SYNC_DROP_CNT_EN
  logic [7:0] drop1, drop0;
`endif

  int         total = 0;
  int         bad   = 0;
  game_data_t expQ1[$];
  game_data_t expQ0[$];
  logic [7:0] framesExp;
  game_data_t monExp1, monExp0;
  game_data_t gA, gB, gC, gD;

  always #5 clock = ~clock;

  tetris_gd_sync #(
    .OVERWRITE(1'b1), .VS_POLARITY(1'b0), .FRAME_CNT_WIDTH(8)
  ) dut1 (
    .clk_i(clock), .rst_i(reset), .gd_i(gdIn1), .gd_valid_i(valid1),
    .gd_ready_o(ready1), .vga_vs_i(vsync), .gd_o(gdOut1), .swap_o(swap1),
    .frame_cnt_o(frame1)
`ifdef TETRIS_GD_SYNC_DROP_CNT_EN
    , .drop_cnt_o(drop1)
`endif
  );

  tetris_gd_sync #(
    .OVERWRITE(1'b0), .VS_POLARITY(1'b0), .FRAME_CNT_WIDTH(8)
  ) dut0 (
    .clk_i(clock), .rst_i(reset), .gd_i(gdIn0), .gd_valid_i(valid0),
    .gd_ready_o(ready0), .vga_vs_i(vsync), .gd_o(gdOut0), .swap_o(swap0),
    .frame_cnt_o(frame0)
`ifdef TETRIS_GD_SYNC_DROP_CNT_EN
    , .drop_cnt_o(drop0)
`endif
  );

  // Builds a snapshot with distinctive filler in the other fields so a
  // wrong copy shows up anywhere in the struct.
  function automatic game_data_t mk(input logic [23:0] score,
                                    input logic [23:0] lines,
                                    input logic [23:0] level);
    game_data_t g;
    g                      = '0;
    g.score                = score;
    g.lines                = lines;
    g.level                = level;
    g.next_block_data      = {score, lines, 16'hA5C3};
    g.field[0][0]          = score[2:0];
    g.field[19][9]         = lines[2:0] ^ 3'b101;
    g.next_block_color     = level[2:0];
    g.next_block_rotation  = score[1:0];
    g.next_block_draw_en   = 1'b1;
    return g;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkGd(input string name, input game_data_t actual,
                         input game_data_t expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Presents a snapshot to one instance until it is accepted, bounded.
  task automatic applyStimulus(input bit sel, input game_data_t g);
    bit done;
    done = 1'b0;
    if (sel) begin
      gdIn1 = g; valid1 = 1'b1;
    end else begin
      gdIn0 = g; valid0 = 1'b1;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      done = sel ? ready1 : ready0;
      @(negedge clock);
    end
    valid1 = 1'b0;
    valid0 = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got no ready, expected ready within 20 cycles");
    end
  endtask

  task automatic vsyncPulse(input int activeCycles);
    vsync = 1'b0;
    repeat (activeCycles) @(negedge clock);
    vsync = 1'b1;
    @(negedge clock);
    framesExp++;
    checkOutput("frame_cnt1", {24'd0, frame1}, {24'd0, framesExp});
    checkOutput("frame_cnt0", {24'd0, frame0}, {24'd0, framesExp});
  endtask

  // Every swap pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (swap1) begin
      if (expQ1.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL swap1_unexpected: got swap, expected none");
      end else begin
        monExp1 = expQ1.pop_front();
        checkGd("swap1_gd", gdOut1, monExp1);
      end
    end
    if (swap0) begin
      if (expQ0.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL swap0_unexpected: got swap, expected none");
      end else begin
        monExp0 = expQ0.pop_front();
        checkGd("swap0_gd", gdOut0, monExp0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    vsync     = 1'b1;
    framesExp = 8'd0;
    gdIn1     = mk(24'h999999, 24'h999, 24'h9);
    gdIn0     = gdIn1;
    valid1    = 1'b1;
    valid0    = 1'b1;

    // reset with valid held high
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("ready1_in_reset", {31'd0, ready1}, 32'd0);
      checkOutput("ready0_in_reset", {31'd0, ready0}, 32'd0);
    end
    checkGd("gd1_reset", gdOut1, '0);
    checkGd("gd0_reset", gdOut0, '0);
    checkOutput("frame_reset", {24'd0, frame1}, 32'd0);
    reset  = 1'b0;
    valid1 = 1'b0;
    valid0 = 1'b0;
    @(negedge clock);
    checkOutput("ready1_idle", {31'd0, ready1}, 32'd1);
    checkOutput("ready0_idle", {31'd0, ready0}, 32'd1);

    // single update
    gA = mk(24'h000123, 24'h0, 24'h0);
    applyStimulus(1'b1, gA);
    repeat (99) @(negedge clock);
    checkOutput("score_hold", {8'd0, gdOut1.score}, 32'h0);
    expQ1.push_back(gA);
    vsync = 1'b0;
    @(negedge clock);
    checkOutput("swap1_pulse", {31'd0, swap1}, 32'd1);
    checkOutput("score_new", {8'd0, gdOut1.score}, 32'h123);
    @(negedge clock);
    checkOutput("swap1_one_cycle", {31'd0, swap1}, 32'd0);
    vsync = 1'b1;
    @(negedge clock);
    framesExp++;
    checkOutput("frame_after_single", {24'd0, frame1}, 32'd1);

    // latest wins
    applyStimulus(1'b1, mk(24'h0, 24'h1, 24'h0));
    applyStimulus(1'b1, mk(24'h0, 24'h2, 24'h0));
    applyStimulus(1'b1, mk(24'h0, 24'h3, 24'h0));
    expQ1.push_back(mk(24'h0, 24'h3, 24'h0));
    vsyncPulse(3);
    checkOutput("lines_latest", {8'd0, gdOut1.lines}, 32'd3);
`ifdef TETRIS_GD_SYNC_DROP_CNT_EN
    checkOutput("drop_cnt1", {24'd0, drop1}, 32'd2);
    checkOutput("drop_cnt0", {24'd0, drop0}, 32'd0);
`endif

    // back-pressure on the OVERWRITE=0 instance
    applyStimulus(1'b0, mk(24'h0, 24'h0, 24'h5));
    gdIn0  = mk(24'h0, 24'h0, 24'h6);
    valid0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("ready0_blocked", {31'd0, ready0}, 32'd0);
      @(negedge clock);
    end
    expQ0.push_back(mk(24'h0, 24'h0, 24'h5));
    vsync = 1'b0;
    checkOutput("ready0_blocked_vs", {31'd0, ready0}, 32'd0);
    @(negedge clock);
    checkOutput("ready0_after_swap", {31'd0, ready0}, 32'd1);
    @(negedge clock);
    checkOutput("ready0_reblocked", {31'd0, ready0}, 32'd0);
    valid0 = 1'b0;
    @(negedge clock);
    vsync = 1'b1;
    @(negedge clock);
    framesExp++;
    checkOutput("level5_shown", {8'd0, gdOut0.level}, 32'd5);
    expQ0.push_back(mk(24'h0, 24'h0, 24'h6));
    vsyncPulse(2);
    checkOutput("level6_shown", {8'd0, gdOut0.level}, 32'd6);

    // accept while pending on the vsync start cycle
    gA = mk(24'h111, 24'h0, 24'h0);
    gB = mk(24'h222, 24'h0, 24'h0);
    applyStimulus(1'b1, gA);
    expQ1.push_back(gA);
    gdIn1  = gB;
    valid1 = 1'b1;
    vsync  = 1'b0;
    @(negedge clock);
    valid1 = 1'b0;
    checkGd("simul_shows_A", gdOut1, gA);
    @(negedge clock);
    vsync = 1'b1;
    @(negedge clock);
    framesExp++;
`ifdef TETRIS_GD_SYNC_DROP_CNT_EN
    checkOutput("drop_cnt_simul", {24'd0, drop1}, 32'd2);
`endif
    expQ1.push_back(gB);
    vsyncPulse(2);
    checkGd("simul_next_B", gdOut1, gB);

    // accept in IDLE on the vsync start cycle: no swap this frame
    gC     = mk(24'h333, 24'h7, 24'h1);
    gdIn1  = gC;
    valid1 = 1'b1;
    vsync  = 1'b0;
    @(negedge clock);
    valid1 = 1'b0;
    checkOutput("idle_accept_no_swap", {31'd0, swap1}, 32'd0);
    checkGd("idle_accept_keeps_B", gdOut1, gB);
    @(negedge clock);
    vsync = 1'b1;
    @(negedge clock);
    framesExp++;
    expQ1.push_back(gC);
    vsyncPulse(2);
    checkGd("idle_accept_next_C", gdOut1, gC);

    // held sync level and frame counter wrap
    while (framesExp != 8'hFF) vsyncPulse(3);
    checkOutput("frame_max", {24'd0, frame1}, 32'hFF);
    vsyncPulse(3);
    checkOutput("frame_wrap", {24'd0, frame1}, 32'h0);

    // reset while pending discards the shadow
    gD = mk(24'h444, 24'h4, 24'h4);
    applyStimulus(1'b1, gD);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset     = 1'b0;
    framesExp = 8'd0;
    checkGd("gd1_after_reset", gdOut1, '0);
    vsyncPulse(2);
    checkGd("gd1_no_swap_after_reset", gdOut1, '0);

    repeat (4) @(negedge clock);
    checkOutput("expq1_drained", expQ1.size(), 32'd0);
    checkOutput("expq0_drained", expQ0.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
